// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-port memory between the CPU fetch port (F, read only)
//   and the CPU data/IO port (D). Each port uses a request/ack handshake, and
//   one memory transaction is in flight at a time. When both ports request in
//   the same cycle, the port that did not win last time is granted, so two
//   ports requesting continuously alternate F, D, F, D...
//
//   Sequence: IDLE -> BUSY (mem_en high until mem_ready) -> ACK (one-cycle
//   ack pulse) -> IDLE. Every output is registered.
//
//   Optional build macro ARB_TIMEOUT_EN: a BUSY transaction that sees no
//   mem_ready for MAX_HOLD cycles is aborted. The abort acks the requester
//   with err=1 and rdata all ones. Without the macro, BUSY waits indefinitely
//   and err is constant 0.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active low
//   f_req      in   fetch request, held with f_addr until f_ack
//   f_addr     in   fetch address
//   d_req      in   data request, held with d_addr/d_we/d_wdata until d_ack
//   d_addr     in   data address
//   d_we       in   data write enable (1 = write)
//   d_wdata    in   data write value
//   f_ack      out  one-cycle completion pulse, fetch port
//   d_ack      out  one-cycle completion pulse, data port
//   rdata      out  read data; valid with an ack and held until the next ack
//   err        out  abort flag, valid with an ack
//   mem_en     out  memory access strobe
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data, valid with mem_ready
//   mem_ready  in   memory completion; only looked at in BUSY
module mem_bus_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [DW-1:0] d_wdata,
  output logic          f_ack,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_ACK  = 2'b10;

  localparam logic SEL_F = 1'b0;
  localparam logic SEL_D = 1'b1;

  logic [1:0] state_reg;
  logic       last_reg;    // port granted most recently
  logic       winner_reg;  // port owning the transaction in flight
  logic       grant_next;  // port that would be granted this cycle
  logic       timeout;     // abort the BUSY transaction at this edge

  // With only one requester, that requester wins. With both requesting, the
  // port that did not win last time wins. d_req alone also covers the
  // no-request case, which IDLE ignores anyway.
  always_comb begin
    grant_next = d_req;
    if (f_req && d_req) begin
      grant_next = ~last_reg;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt_reg;
  logic [CW-1:0] hold_cnt_next;

  // The abort fires on the BUSY cycle whose increment would bring the count
  // up to MAX_HOLD. That gives exactly MAX_HOLD stalled BUSY cycles before
  // the ack. A mem_ready in that same cycle still completes normally.
  assign hold_cnt_next = hold_cnt_reg + 1'b1;
  assign timeout       = (state_reg == ST_BUSY) && !mem_ready &&
                         (hold_cnt_next == CW'(MAX_HOLD));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_cnt_reg <= '0;
    end else if (state_reg != ST_BUSY) begin
      hold_cnt_reg <= '0;
    end else if (!mem_ready) begin
      hold_cnt_reg <= hold_cnt_next;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= ST_IDLE;
      last_reg   <= SEL_D;  // makes F the winner of the first tie
      winner_reg <= SEL_F;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // The ack is a pulse: it only stays high if set again below.
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          err <= 1'b0;
          if (f_req || d_req) begin
            last_reg   <= grant_next;
            winner_reg <= grant_next;
            mem_en     <= 1'b1;
            mem_addr   <= (grant_next == SEL_D) ? d_addr : f_addr;
            mem_we     <= (grant_next == SEL_D) && d_we;
            mem_wdata  <= (grant_next == SEL_D) ? d_wdata : '0;
            state_reg  <= ST_BUSY;
          end else begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end

        ST_BUSY: begin
          if (mem_ready) begin
            if (!mem_we) begin
              rdata <= mem_rdata;  // a write leaves rdata untouched
            end
            f_ack     <= (winner_reg == SEL_F);
            d_ack     <= (winner_reg == SEL_D);
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= ST_ACK;
          end else if (timeout) begin
            rdata     <= '1;
            f_ack     <= (winner_reg == SEL_F);
            d_ack     <= (winner_reg == SEL_D);
            err       <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= ST_ACK;
          end
        end

        ST_ACK: begin
          // Requests are ignored here. Arbitration resumes in IDLE next cycle.
          err       <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter.
// Inputs are driven and outputs are sampled on the falling clock edge.
// The directed tasks cover reset, single read, write, fairness, slow memory
// and timeout. The random task keeps a reference model in the bench: a
// memory array, the pending request of each port, and the rule that the
// port which did not win last time wins a tie.
module tb_mem_bus_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 15;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_wdata = '0;
  logic          f_ack;
  logic          d_ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .f_ack(f_ack), .d_ack(d_ack), .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    // Check the outputs while reset is held.
    @(negedge CLK);
    total++;
    if ({f_ack, d_ack, err, mem_en, mem_we, rdata, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_hold: outputs=%h required 0",
                      {f_ack, d_ack, err, mem_en, mem_we, rdata, mem_addr, mem_wdata});
    end
    RST = 1'b1;
    @(negedge CLK);
    d_req = 1'b1; d_addr = 8'h77; d_we = 1'b1; d_wdata = 8'h3E;
    @(negedge CLK);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h77) begin
      bad++; $display("FAIL reset_pre_busy: mem_en=%b addr=%h required 1/77", mem_en, mem_addr);
    end
    // Assert reset in the middle of BUSY; the outputs must clear at once.
    #2 RST = 1'b0;
    #1;
    total++;
    if ({f_ack, d_ack, err, mem_en, mem_we, rdata, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_async: outputs=%h required 0",
                      {f_ack, d_ack, err, mem_en, mem_we, rdata, mem_addr, mem_wdata});
    end
    @(negedge CLK);
    RST = 1'b1;
    f_req = 1'b1; f_addr = 8'h21;
    d_req = 1'b1; d_addr = 8'h42; d_we = 1'b1; d_wdata = 8'h99;
    @(negedge CLK);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h21 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
      bad++; $display("FAIL reset_first_tie: en=%b addr=%h we=%b wd=%h required 1/21/0/00",
                      mem_en, mem_addr, mem_we, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 8'h11;
    @(negedge CLK);
    total++;
    if (f_ack !== 1'b1 || d_ack !== 1'b0 || rdata !== 8'h11) begin
      bad++; $display("FAIL reset_first_ack: f_ack=%b d_ack=%b rdata=%h required 1/0/11",
                      f_ack, d_ack, rdata);
    end
    $display("reset: F granted first after reset, rdata=%h", rdata);
    do_reset();
  endtask

  task automatic test_single_read();
    d_req = 1'b1; d_addr = 8'h3C; d_we = 1'b0;
    @(negedge CLK);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 8'h3C || mem_we !== 1'b0 || d_ack !== 1'b0) begin
      bad++; $display("FAIL read_issue: en=%b addr=%h we=%b ack=%b required 1/3c/0/0",
                      mem_en, mem_addr, mem_we, d_ack);
    end
    mem_ready = 1'b1; mem_rdata = 8'hA5;
    @(negedge CLK);
    total++;
    if (d_ack !== 1'b1 || f_ack !== 1'b0 || rdata !== 8'hA5 || err !== 1'b0) begin
      bad++; $display("FAIL read_ack: d_ack=%b f_ack=%b rdata=%h err=%b required 1/0/a5/0",
                      d_ack, f_ack, rdata, err);
    end
    d_req = 1'b0; mem_ready = 1'b0; mem_rdata = 8'h00;
    @(negedge CLK);
    total++;
    if (d_ack !== 1'b0 || mem_en !== 1'b0) begin
      bad++; $display("FAIL read_pulse: d_ack=%b mem_en=%b required 0/0", d_ack, mem_en);
    end
    $display("single read: addr=3c rdata=%h", rdata);
  endtask

  task automatic test_write();
    d_req = 1'b1; d_addr = 8'h10; d_we = 1'b1; d_wdata = 8'h5A; mem_rdata = 8'h33;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h10 ||
          mem_wdata !== 8'h5A || d_ack !== 1'b0) begin
        bad++; $display("FAIL write_hold%0d: en=%b we=%b addr=%h wd=%h ack=%b required 1/1/10/5a/0",
                        i, mem_en, mem_we, mem_addr, mem_wdata, d_ack);
      end
    end
    mem_ready = 1'b1;
    @(negedge CLK);
    total++;
    if (d_ack !== 1'b1 || rdata !== 8'hA5 || err !== 1'b0) begin
      bad++; $display("FAIL write_ack: d_ack=%b rdata=%h err=%b required 1/a5/0", d_ack, rdata, err);
    end
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    @(negedge CLK);
    total++;
    if (d_ack !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL write_pulse: d_ack=%b mem_we=%b required 0/0", d_ack, mem_we);
    end
    $display("write: addr=10 wdata=5a rdata kept %h", rdata);
  endtask

  task automatic test_fairness();
    int nacks;
    int last_cyc;
    do_reset();
    f_req = 1'b1; f_addr = 8'h0F;
    d_req = 1'b1; d_addr = 8'hD0; d_we = 1'b0;
    nacks = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 60 && nacks < 8; cyc++) begin
      @(negedge CLK);
      if (f_ack && d_ack) begin
        total++; bad++; $display("FAIL fair_coincident: both acks high at cycle %0d", cyc);
      end else if (f_ack || d_ack) begin
        total++;
        if (d_ack !== logic'(nacks % 2) || rdata !== 8'((cyc - 1) & 8'hFF)) begin
          bad++; $display("FAIL fair_order%0d: d_ack=%b rdata=%h required %0d/%h",
                          nacks, d_ack, rdata, nacks % 2, 8'((cyc - 1) & 8'hFF));
        end
        if (nacks > 0) begin
          total++;
          if (cyc - last_cyc != 3) begin
            bad++; $display("FAIL fair_spacing%0d: spacing=%0d required 3", nacks, cyc - last_cyc);
          end
        end
        $display("fairness ack %0d: port=%s cycle=%0d", nacks, d_ack ? "D" : "F", cyc);
        last_cyc = cyc;
        nacks++;
      end
      // The memory answers immediately, with a value tied to the cycle number.
      mem_ready = mem_en;
      mem_rdata = 8'(cyc & 8'hFF);
    end
    total++;
    if (nacks != 8) begin
      bad++; $display("FAIL fair_count: acks=%0d required 8", nacks);
    end
    f_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_slow_memory();
    d_req = 1'b1; d_addr = 8'h5E; d_we = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      total++;
      if (mem_en !== 1'b1 || mem_addr !== 8'h5E || mem_we !== 1'b0 || d_ack !== 1'b0) begin
        bad++; $display("FAIL slow_busy%0d: en=%b addr=%h we=%b ack=%b required 1/5e/0/0",
                        i, mem_en, mem_addr, mem_we, d_ack);
      end
      if (i == 2) d_req = 1'b0;  // requester gives up while the access is still in BUSY
      if (i == 6) begin
        mem_ready = 1'b1; mem_rdata = 8'hC3;
      end
    end
    @(negedge CLK);
    total++;
    if (d_ack !== 1'b1 || rdata !== 8'hC3) begin
      bad++; $display("FAIL slow_ack: d_ack=%b rdata=%h required 1/c3", d_ack, rdata);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      total++;
      if (mem_en !== 1'b0 || d_ack !== 1'b0) begin
        bad++; $display("FAIL slow_after%0d: en=%b ack=%b required 0/0", i, mem_en, d_ack);
      end
    end
    $display("slow memory: ack after 6 busy cycles, rdata=%h", rdata);
  endtask

  task automatic test_timeout();
    int count;
    bit got;
    do_reset();
    f_req = 1'b1; f_addr = 8'hAB;
    d_req = 1'b1; d_addr = 8'hCD; d_we = 1'b0;
    mem_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
    count = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      if (f_ack || d_ack) begin
        got = 1'b1;
        total++;
        if (f_ack !== 1'b1 || d_ack !== 1'b0 || err !== 1'b1 || rdata !== 8'hFF || count != MAX_HOLD) begin
          bad++; $display("FAIL timeout_abort: f=%b d=%b err=%b rdata=%h busy=%0d required 1/0/1/ff/%0d",
                          f_ack, d_ack, err, rdata, count, MAX_HOLD);
        end
        f_req = 1'b0;
      end else if (mem_en) begin
        count++;
      end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL timeout_none: no abort ack, required one after %0d cycles", MAX_HOLD);
    end
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 8'hCD) begin
      bad++; $display("FAIL timeout_next: en=%b addr=%h required 1/cd", mem_en, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 8'h44;
    @(negedge CLK);
    total++;
    if (d_ack !== 1'b1 || err !== 1'b0 || rdata !== 8'h44) begin
      bad++; $display("FAIL timeout_normal: d_ack=%b err=%b rdata=%h required 1/0/44", d_ack, err, rdata);
    end
    $display("timeout: abort after %0d busy cycles, then D served", count);
`else
    count = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      total++;
      if (f_ack !== 1'b0 || d_ack !== 1'b0 || err !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'hAB) begin
        bad++; $display("FAIL no_timeout%0d: f=%b d=%b err=%b en=%b addr=%h required 0/0/0/1/ab",
                        i, f_ack, d_ack, err, mem_en, mem_addr);
      end
      count++;
    end
    $display("no timeout build: still busy after %0d cycles", count);
`endif
    f_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_random();
    logic [7:0] ref_mem [0:255];
    bit         fq, dq, model_last, ready_sent, exp_w;
    int         owner, lat, busy_n, wait_n, nacks;
    logic [7:0] g_addr, g_wdata, exp_rdata;
    bit         g_we;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    do_reset();
    fq = 1'b0; dq = 1'b0; model_last = 1'b1; ready_sent = 1'b0;
    owner = -1; lat = 0; busy_n = 0; wait_n = 0; nacks = 0;
    g_addr = '0; g_wdata = '0; g_we = 1'b0; exp_rdata = '0;
    for (int cyc = 0; cyc < 3000 && nacks < 150; cyc++) begin
      @(negedge CLK);
      // Check the acks: one is due exactly one cycle after mem_ready was given.
      if (ready_sent) begin
        total++;
        if (f_ack === d_ack || d_ack !== logic'(owner) || rdata !== exp_rdata || err !== 1'b0) begin
          bad++; $display("FAIL rnd_ack%0d: f=%b d=%b rdata=%h err=%b required owner=%0d rdata=%h err=0",
                          nacks, f_ack, d_ack, rdata, err, owner, exp_rdata);
        end
        $display("rnd txn %0d: port=%s addr=%h we=%b rdata=%h", nacks, owner ? "D" : "F",
                 g_addr, g_we, rdata);
        if (owner == 0) fq = 1'b0; else dq = 1'b0;
        owner = -1; ready_sent = 1'b0; nacks++;
      end else if (f_ack || d_ack) begin
        total++; bad++;
        $display("FAIL rnd_spurious: f=%b d=%b required 0/0 at cycle %0d", f_ack, d_ack, cyc);
      end
      mem_ready = 1'b0;
      if (mem_en) begin
        if (owner < 0) begin
          // New grant: the winner follows from the requests pending at the grant edge.
          exp_w   = (fq && dq) ? !model_last : dq;
          g_addr  = exp_w ? d_addr : f_addr;
          g_we    = exp_w ? d_we : 1'b0;
          g_wdata = exp_w ? d_wdata : 8'h00;
          total++;
          if (!(fq || dq) || mem_addr !== g_addr || mem_we !== g_we || mem_wdata !== g_wdata) begin
            bad++; $display("FAIL rnd_grant: addr=%h we=%b wd=%h required %h/%b/%h",
                            mem_addr, mem_we, mem_wdata, g_addr, g_we, g_wdata);
          end
          owner = int'(exp_w); model_last = exp_w;
          lat = $urandom_range(0, 4); busy_n = 0; wait_n = 0;
        end else begin
          total++;
          if (mem_addr !== g_addr || mem_we !== g_we || mem_wdata !== g_wdata) begin
            bad++; $display("FAIL rnd_stable: addr=%h we=%b wd=%h required %h/%b/%h",
                            mem_addr, mem_we, mem_wdata, g_addr, g_we, g_wdata);
          end
        end
        if (busy_n == lat) begin
          mem_ready = 1'b1;
          if (g_we) begin
            ref_mem[g_addr] = g_wdata;
            mem_rdata = 8'($urandom);
          end else begin
            mem_rdata = ref_mem[g_addr];
            exp_rdata = ref_mem[g_addr];
          end
          ready_sent = 1'b1;
        end
        busy_n++;
      end else begin
        if (owner >= 0) begin
          total++; bad++;
          $display("FAIL rnd_en_drop: mem_en=0 required 1 for owner %0d", owner);
          owner = -1;
        end
        // Outside BUSY, mem_ready is driven with noise.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = 8'($urandom);
        if (fq || dq) wait_n++;
        if (wait_n > 6) begin
          total++; bad++;
          $display("FAIL rnd_starve: no grant for %0d cycles, required within 6", wait_n);
          wait_n = 0;
        end
      end
      // Raise new requests; a port keeps its fields while it is pending.
      if (!fq && $urandom_range(0, 2) == 0) begin
        fq = 1'b1; f_addr = 8'($urandom_range(0, 15));
      end
      if (!dq && $urandom_range(0, 2) == 0) begin
        dq = 1'b1; d_addr = 8'($urandom_range(0, 15));
        d_we = 1'($urandom_range(0, 1)); d_wdata = 8'($urandom);
      end
      f_req = fq; d_req = dq;
    end
    total++;
    if (nacks < 150) begin
      bad++; $display("FAIL rnd_progress: acks=%0d required 150", nacks);
    end
    f_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_fairness();
    test_slow_memory();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
